// File: rtl/sdram_arbiter.sv
// Two-port front end for the SDRAM controller: arbitrates fetch and data requests,
// converts byte addresses to halfword address plus odd flag, sequences the
// enable/ready handshake and reports illegal requests and controller timeouts.
module sdram_arbiter #(
    parameter bit          DPRIO   = 1'b0,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [24:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic [24:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_width,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_enable,
    output logic [23:0] mem_addr,
    output logic        mem_odd_access,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_data_width,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {StIdle, StArm, StIssue, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic        port_q, port_d;   // granted port: 1 = data, 0 = fetch
    logic        last_q, last_d;   // last granted port: 1 = data, 0 = fetch
    logic [24:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  width_q, width_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  tcnt_q, tcnt_d;

    logic        pick_data;
    logic [24:0] sel_addr;
    logic [1:0]  sel_width;
    logic        sel_illegal;
    logic        timeout_hit;

    // Arbitration choice and legality of the selected request
    always_comb begin
        // Round-robin: data wins a conflict unless it was the last port served
        pick_data = d_req && (!i_req || DPRIO || !last_q);
        if (pick_data) begin
            sel_addr  = d_addr;
            sel_width = d_width;
        end else begin
            sel_addr  = i_addr;
            sel_width = 2'b10;
        end
        sel_illegal = (sel_width == 2'b11) || ((sel_width == 2'b10) && sel_addr[0]);
    end

    assign timeout_hit = (tcnt_q == 8'(TIMEOUT - 1));

    // Next-state and request-register updates
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        last_d  = last_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        width_d = width_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    port_d  = pick_data;
                    addr_d  = sel_addr;
                    width_d = sel_width;
                    we_d    = pick_data ? d_we : 1'b0;
                    wdata_d = pick_data ? d_wdata : 32'h0;
                    err_d   = sel_illegal;
                    rdata_d = 32'h0;
                    state_d = sel_illegal ? StResp : StArm;
                end
            end
            StArm: begin
                // No timeout here: ready stays low through controller init
                if (mem_ready) begin
                    tcnt_d  = 8'h0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = StResp;
                end else begin
                    tcnt_d = tcnt_q + 8'h1;
                    // Ready held high means a refresh is in progress; keep enable up
                    if (!mem_ready) begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (mem_ready) begin
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'h0 : mem_read_data;
                    state_d = StResp;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = StResp;
                end else begin
                    tcnt_d = tcnt_q + 8'h1;
                end
            end
            StResp: begin
                last_d  = port_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and request registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            port_q  <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            width_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            width_q <= width_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign i_ack   = (state_q == StResp) && !port_q;
    assign d_ack   = (state_q == StResp) && port_q;
    assign i_rdata = i_ack ? rdata_q : 32'h0;
    assign d_rdata = d_ack ? rdata_q : 32'h0;
    assign i_err   = i_ack && err_q;
    assign d_err   = d_ack && err_q;

    assign mem_enable     = (state_q == StIssue);
    assign mem_addr       = addr_q[24:1];
    assign mem_odd_access = addr_q[0];
    assign mem_write      = we_q;
    assign mem_write_data = wdata_q;
    assign mem_data_width = width_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter with a behavioural SDRAM controller model
// and a scoreboard of expected completions.
module tb_sdram_arbiter;

    localparam bit          DPRIO   = 1'b0;
    localparam int unsigned TIMEOUT = 64;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [24:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic [24:0] d_addr;
    logic        d_we;
    logic [31:0] d_wdata;
    logic [1:0]  d_width;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_enable;
    logic [23:0] mem_addr;
    logic        mem_odd_access;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [1:0]  mem_data_width;
    logic [31:0] mem_read_data;
    logic        mem_ready;

    sdram_arbiter #(
        .DPRIO   (DPRIO),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_ack          (i_ack),
        .i_rdata        (i_rdata),
        .i_err          (i_err),
        .d_req          (d_req),
        .d_addr         (d_addr),
        .d_we           (d_we),
        .d_wdata        (d_wdata),
        .d_width        (d_width),
        .d_ack          (d_ack),
        .d_rdata        (d_rdata),
        .d_err          (d_err),
        .mem_enable     (mem_enable),
        .mem_addr       (mem_addr),
        .mem_odd_access (mem_odd_access),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_data_width (mem_data_width),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          port;   // 1 = data
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];
    int acks_seen = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [24:0] a);
        return {7'h0, a} ^ 32'h5A00_0000;
    endfunction

    // ---------------- controller model ----------------
    int          init_len = 6100;
    int          init_left = 0;
    int          busy_left = 0;
    int          refresh_left = 0;
    int          refresh_req_cnt = 0;
    int          refresh_ack_cnt = 0;
    bit          hang = 1'b0;
    bit          hang_act = 1'b0;
    logic [31:0] mem_q [logic [24:0]];
    logic [31:0] pend_rdata = '0;
    logic [23:0] acc_mem_addr = '0;
    logic        acc_odd = 1'b0;
    logic        acc_we = 1'b0;
    logic [31:0] acc_wdata = '0;
    int          en_cycles = 0;
    int          en_during_init = 0;
    int          en_during_refresh = 0;

    // Controller model: init delay, refresh stall, fixed access latency, optional hang
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_ready     <= 1'b0;
            mem_read_data <= '0;
            init_left     <= init_len;
            busy_left     <= 0;
            refresh_left  <= 0;
            hang_act      <= 1'b0;
        end else begin
            if (mem_enable) en_cycles <= en_cycles + 1;
            if (mem_enable && init_left > 0) en_during_init <= en_during_init + 1;
            if (mem_enable && refresh_left > 0) en_during_refresh <= en_during_refresh + 1;
            if (init_left > 0) begin
                init_left <= init_left - 1;
                mem_ready <= (init_left == 1);
            end else if (hang_act) begin
                if (!hang) begin
                    hang_act  <= 1'b0;
                    mem_ready <= 1'b1;
                end
            end else if (busy_left > 0) begin
                busy_left <= busy_left - 1;
                if (busy_left == 1) begin
                    mem_ready     <= 1'b1;
                    mem_read_data <= pend_rdata;
                end
            end else if (refresh_left > 0) begin
                refresh_left <= refresh_left - 1;
            end else if (mem_enable && mem_ready) begin
                if (refresh_req_cnt != refresh_ack_cnt) begin
                    refresh_ack_cnt <= refresh_req_cnt;
                    refresh_left    <= 6;
                end else begin
                    acc_mem_addr <= mem_addr;
                    acc_odd      <= mem_odd_access;
                    acc_we       <= mem_write;
                    acc_wdata    <= mem_write_data;
                    mem_ready    <= 1'b0;
                    if (mem_write) begin
                        mem_q[{mem_addr, mem_odd_access}] = mem_write_data;
                        pend_rdata <= 32'h0;
                    end else if (mem_q.exists({mem_addr, mem_odd_access})) begin
                        pend_rdata <= mem_q[{mem_addr, mem_odd_access}];
                    end else begin
                        pend_rdata <= dflt({mem_addr, mem_odd_access});
                    end
                    if (hang) hang_act <= 1'b1;
                    else busy_left <= 3;
                end
            end
        end
    end

    // Scoreboard: every ack pops the oldest expectation and compares it
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (i_ack || d_ack)) begin
            acks_seen++;
            check("single_ack", 64'(i_ack && d_ack), 64'(0));
            check("ack_expected", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ack_port", 64'(d_ack), 64'(e.port));
                check("ack_rdata", 64'(d_ack ? d_rdata : i_rdata), 64'(e.rdata));
                check("ack_err", 64'(d_ack ? d_err : i_err), 64'(e.err));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input bit port, input int budget, output int lat);
        logic got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < budget) begin
            @(negedge clk);
            lat++;
            got = port ? d_ack : i_ack;
        end
        check(port ? "d_ack_in_budget" : "i_ack_in_budget", 64'(got), 64'(1));
    endtask

    task automatic d_access(input logic [24:0] a, input logic we, input logic [31:0] wd,
                            input logic [1:0] w, input logic [31:0] er, input logic ee,
                            output int lat);
        exp_t e;
        d_addr  = a;
        d_we    = we;
        d_wdata = wd;
        d_width = w;
        d_req   = 1'b1;
        e.port = 1'b1; e.rdata = er; e.err = ee;
        sb.push_back(e);
        wait_ack(1'b1, 400, lat);
        d_req = 1'b0;
    endtask

    task automatic i_access(input logic [24:0] a, input logic [31:0] er, input logic ee,
                            output int lat);
        exp_t e;
        i_addr = a;
        i_req  = 1'b1;
        e.port = 1'b0; e.rdata = er; e.err = ee;
        sb.push_back(e);
        wait_ack(1'b0, 400, lat);
        i_req = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat;
        int   a0;
        int   e0;
        int   r0;
        int   t;
        exp_t e;
        logic [24:0] ia [4];
        logic [24:0] da [4];
        int   pi, pd;
        bit   last;

        rst_n   = 1'b0;
        i_req   = 1'b1;
        i_addr  = 25'h000100;
        d_req   = 1'b0;
        d_addr  = '0;
        d_we    = 1'b0;
        d_wdata = '0;
        d_width = '0;
        tick(3);

        // Reset state
        check("rst_i_ack", 64'(i_ack), 64'(0));
        check("rst_d_ack", 64'(d_ack), 64'(0));
        check("rst_i_err", 64'(i_err), 64'(0));
        check("rst_d_err", 64'(d_err), 64'(0));
        check("rst_i_rdata", 64'(i_rdata), 64'(0));
        check("rst_d_rdata", 64'(d_rdata), 64'(0));
        check("rst_mem_enable", 64'(mem_enable), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_odd", 64'(mem_odd_access), 64'(0));
        check("rst_mem_write", 64'(mem_write), 64'(0));
        check("rst_mem_wdata", 64'(mem_write_data), 64'(0));
        check("rst_mem_width", 64'(mem_data_width), 64'(0));

        // Init: fetch held from reset while the controller keeps ready low
        a0 = acks_seen;
        e.port = 1'b0; e.rdata = dflt(25'h000100); e.err = 1'b0;
        sb.push_back(e);
        rst_n = 1'b1;
        wait_ack(1'b0, 7000, lat);
        i_req = 1'b0;
        tick(2);
        check("init_no_enable_before_ready", 64'(en_during_init), 64'(0));
        check("init_one_ack", 64'(acks_seen - a0), 64'(1));

        // Halfword write then read back
        d_access(25'h0000402, 1'b1, 32'h0000BEEF, 2'b01, 32'h0, 1'b0, lat);
        check("wr_mem_addr", 64'(acc_mem_addr), 64'h000201);
        check("wr_mem_odd", 64'(acc_odd), 64'(0));
        check("wr_mem_write", 64'(acc_we), 64'(1));
        check("wr_mem_wdata", 64'(acc_wdata), 64'h0000BEEF);
        tick(1);
        d_access(25'h0000402, 1'b0, 32'h0, 2'b01, 32'h0000BEEF, 1'b0, lat);
        check("rd_mem_write", 64'(acc_we), 64'(0));
        tick(1);
        // Odd byte read sets the odd flag
        d_access(25'h0000403, 1'b0, 32'h0, 2'b00, dflt(25'h0000403), 1'b0, lat);
        check("odd_mem_addr", 64'(acc_mem_addr), 64'h000201);
        check("odd_mem_odd", 64'(acc_odd), 64'(1));
        tick(2);

        // Refresh stall at the start of ISSUE
        a0 = acks_seen;
        r0 = en_during_refresh;
        refresh_req_cnt++;
        i_access(25'h0000200, dflt(25'h0000200), 1'b0, lat);
        tick(3);
        check("refresh_enable_cycles", 64'(en_during_refresh - r0), 64'(6));
        check("refresh_one_ack", 64'(acks_seen - a0), 64'(1));

        // Illegal requests: ack in the cycle after the IDLE sample cycle, no enable
        e0 = en_cycles;
        d_access(25'h0000003, 1'b0, 32'h0, 2'b10, 32'h0, 1'b1, lat);
        check("illegal_w10_latency", 64'(lat), 64'(1));
        tick(2);
        d_access(25'h0000008, 1'b0, 32'h0, 2'b11, 32'h0, 1'b1, lat);
        check("illegal_w11_latency", 64'(lat), 64'(1));
        tick(2);
        check("illegal_no_enable", 64'(en_cycles - e0), 64'(0));

        // Timeout: controller accepts and never returns ready
        hang = 1'b1;
        e.port = 1'b0; e.rdata = 32'h0; e.err = 1'b1;
        sb.push_back(e);
        i_addr = 25'h0000300;
        i_req  = 1'b1;
        t = 0;
        while (!mem_enable && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("timeout_issue_seen", 64'(mem_enable), 64'(1));
        t = 0;
        while (!i_ack && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("timeout_latency", 64'(t), 64'(TIMEOUT));
        i_req = 1'b0;
        hang  = 1'b0;
        tick(3);
        i_access(25'h0000300, dflt(25'h0000300), 1'b0, lat);
        tick(2);

        // Reset mid-transaction abandons it with no ack
        init_len = 10;
        i_addr = 25'h0000500;
        i_req  = 1'b1;
        t = 0;
        while (!mem_enable && t < 50) begin
            @(negedge clk);
            t++;
        end
        rst_n = 1'b0;
        i_req = 1'b0;
        sb.delete();
        a0 = acks_seen;
        tick(2);
        check("midrst_enable", 64'(mem_enable), 64'(0));
        check("midrst_mem_addr", 64'(mem_addr), 64'(0));
        rst_n = 1'b1;
        tick(30);
        check("midrst_no_ack", 64'(acks_seen - a0), 64'(0));

        // Conflicts: both ports keep requesting, 4 requests each
        for (int k = 0; k < 4; k++) begin
            ia[k] = 25'h0001000 + 25'(4 * k);
            da[k] = 25'h0002000 + 25'(4 * k);
        end
        pi = 0;
        pd = 0;
        last = 1'b0;
        while (pi < 4 || pd < 4) begin
            bit win;
            if (pi < 4 && pd < 4) win = DPRIO ? 1'b1 : !last;
            else win = (pd < 4);
            e.port = win;
            e.err  = 1'b0;
            if (win) begin
                e.rdata = dflt(da[pd]);
                pd++;
            end else begin
                e.rdata = dflt(ia[pi]);
                pi++;
            end
            sb.push_back(e);
            last = win;
        end
        a0 = acks_seen;
        d_we    = 1'b0;
        d_width = 2'b10;
        fork
            begin
                int l;
                for (int k = 0; k < 4; k++) begin
                    i_addr = ia[k];
                    i_req  = 1'b1;
                    wait_ack(1'b0, 400, l);
                end
                i_req = 1'b0;
            end
            begin
                int l;
                for (int k = 0; k < 4; k++) begin
                    d_addr = da[k];
                    d_req  = 1'b1;
                    wait_ack(1'b1, 400, l);
                end
                d_req = 1'b0;
            end
        join
        tick(3);
        check("conflict_ack_count", 64'(acks_seen - a0), 64'(8));
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
